// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: valid/ready word in, serial shift out/in, parallel word back.
// Optional abort input enabled by defining SHIFT_SEQ_ABORT_EN.
module shift_seq_ctrl #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_dir,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic             ser_out,
    output logic             ser_en,
    input  logic             ser_in,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [GW-1:0] LAST_GAP =
        (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shifted;
    logic             dir_q;
    logic [CW-1:0]    cnt_q;
    logic [GW-1:0]    gap_q;
    logic             abort_req;
    logic             accept;
    logic             last_bit;

`ifdef SHIFT_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign accept   = tx_valid & tx_ready;
    assign last_bit = (cnt_q == LAST_BIT);
    assign shifted  = dir_q ? {ser_in, shreg_q[WIDTH-1:1]}
                            : {shreg_q[WIDTH-2:0], ser_in};

    // Port outputs decoded from state and the shift register only.
    always_comb begin
        tx_ready = reset & (state_q == IDLE);
        busy     = (state_q != IDLE);
        ser_en   = (state_q == SHIFT);
        ser_out  = ser_en & (dir_q ? shreg_q[0] : shreg_q[WIDTH-1]);
    end

    // Next-state: abort beats frame completion; GAP only exists if configured.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = SHIFT;
            end
            SHIFT: begin
                if (abort_req) begin
                    state_d = IDLE;
                end else if (last_bit) begin
                    state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (abort_req || gap_q == LAST_GAP) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Shift register, counters and receive word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_q  <= '0;
            dir_q    <= 1'b0;
            cnt_q    <= '0;
            gap_q    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        shreg_q <= tx_data;
                        dir_q   <= tx_dir;
                        cnt_q   <= '0;
                    end
                end
                SHIFT: begin
                    if (abort_req) begin
                        shreg_q <= '0;
                        cnt_q   <= '0;
                    end else if (last_bit) begin
                        shreg_q  <= shifted;
                        cnt_q    <= '0;
                        gap_q    <= '0;
                        rx_data  <= shifted;
                        rx_valid <= 1'b1;
                    end else begin
                        shreg_q <= shifted;
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
                GAP: begin
                    if (abort_req) begin
                        shreg_q <= '0;
                        cnt_q   <= '0;
                        gap_q   <= '0;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed vector table plus reset, back-to-back and
// abort sequences for shift_seq_ctrl (GAP_CYCLES 0 and 2 instances).
module tb_shift_seq_ctrl;

    typedef struct {
        logic [7:0] data;
        logic       dir;
        logic       lb;
        logic [7:0] pat;
        logic [7:0] exp_ser;
        logic [7:0] exp_rx;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       tx_valid;
    logic       tx_valid2;
    logic [7:0] tx_data;
    logic       tx_dir;
    logic       lb;
    logic       pat_bit;
    logic       abort;

    logic       tx_ready, ser_out, ser_en, ser_in, rx_valid, busy;
    logic [7:0] rx_data;
    logic       tx_ready2, ser_out2, ser_en2, ser_in2, rx_valid2, busy2;
    logic [7:0] rx_data2;

    int checks = 0;
    int errors = 0;

    vec_t vecs[6];

    assign ser_in  = lb ? ser_out : pat_bit;
    assign ser_in2 = ser_out2;

    shift_seq_ctrl #(.WIDTH(8), .GAP_CYCLES(0)) dut0 (
        .clk      (clk),
        .reset    (reset),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_dir   (tx_dir),
`ifdef SHIFT_SEQ_ABORT_EN
        .abort    (abort),
`endif
        .ser_out  (ser_out),
        .ser_en   (ser_en),
        .ser_in   (ser_in),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .busy     (busy)
    );

    shift_seq_ctrl #(.WIDTH(8), .GAP_CYCLES(2)) dut2 (
        .clk      (clk),
        .reset    (reset),
        .tx_valid (tx_valid2),
        .tx_ready (tx_ready2),
        .tx_data  (tx_data),
        .tx_dir   (tx_dir),
`ifdef SHIFT_SEQ_ABORT_EN
        .abort    (1'b0),
`endif
        .ser_out  (ser_out2),
        .ser_en   (ser_en2),
        .ser_in   (ser_in2),
        .rx_valid (rx_valid2),
        .rx_data  (rx_data2),
        .busy     (busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic run_frame(input vec_t v);
        tx_data  = v.data;
        tx_dir   = v.dir;
        lb       = v.lb;
        tx_valid = 1'b1;
        check("frame_ready", tx_ready, 1);
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = ~v.data;
        tx_dir   = ~v.dir;
        for (int i = 0; i < 8; i++) begin
            pat_bit = v.pat[7-i];
            check("shift_en", ser_en, 1);
            check("shift_out", ser_out, v.exp_ser[7-i]);
            check("shift_no_rxv", rx_valid, 0);
            @(negedge clk);
        end
        check("end_en", ser_en, 0);
        check("end_out", ser_out, 0);
        check("end_rxv", rx_valid, 1);
        check("end_rxd", rx_data, v.exp_rx);
        check("end_busy", busy, 0);
        check("end_ready", tx_ready, 1);
        @(negedge clk);
        check("post_rxv", rx_valid, 0);
        check("post_rxd", rx_data, v.exp_rx);
    endtask

    initial begin
        vecs[0] = '{8'hB4, 1'b0, 1'b1, 8'h00, 8'hB4, 8'hB4};
        vecs[1] = '{8'hB4, 1'b1, 1'b1, 8'h00, 8'h2D, 8'hB4};
        vecs[2] = '{8'h00, 1'b0, 1'b0, 8'hDB, 8'h00, 8'hDB};
        vecs[3] = '{8'h3C, 1'b1, 1'b1, 8'h00, 8'h3C, 8'h3C};
        vecs[4] = '{8'h81, 1'b0, 1'b0, 8'h01, 8'h81, 8'h01};
        vecs[5] = '{8'hF0, 1'b1, 1'b0, 8'h80, 8'h0F, 8'h01};

        reset     = 1'b0;
        tx_valid  = 1'b1;
        tx_valid2 = 1'b0;
        tx_data   = 8'hB4;
        tx_dir    = 1'b0;
        lb        = 1'b1;
        pat_bit   = 1'b0;
        abort     = 1'b0;

        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_ready", tx_ready, 0);
            check("rst_en", ser_en, 0);
            check("rst_busy", busy, 0);
        end
        check("rst_out", ser_out, 0);
        check("rst_rxv", rx_valid, 0);
        check("rst_rxd", rx_data, 0);
        tx_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check("rel_ready", tx_ready, 1);
        check("rel_busy", busy, 0);

        for (int k = 0; k < 6; k++) run_frame(vecs[k]);

        tx_data  = 8'hA5;
        tx_dir   = 1'b0;
        lb       = 1'b1;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_en_before", ser_en, 1);
        reset = 1'b0;
        #1;
        check("mid_en", ser_en, 0);
        check("mid_busy", busy, 0);
        check("mid_ready", tx_ready, 0);
        check("mid_rxd", rx_data, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("mid_no_rxv", rx_valid, 0);
            check("mid_idle", busy, 0);
        end
        check("mid_rxd_after", rx_data, 0);
        run_frame('{8'h3C, 1'b0, 1'b1, 8'h00, 8'h3C, 8'h3C});

        tx_data   = 8'h5A;
        tx_dir    = 1'b0;
        lb        = 1'b1;
        tx_valid  = 1'b1;
        tx_valid2 = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            logic en0, rv0, en2, rv2;
            @(negedge clk);
            if (k == 10) tx_valid = 1'b0;
            if (k == 12) tx_valid2 = 1'b0;
            en0 = (k >= 1 && k <= 8) || (k >= 10 && k <= 17);
            rv0 = (k == 9) || (k == 18);
            en2 = (k >= 1 && k <= 8) || (k >= 12 && k <= 19);
            rv2 = (k == 9) || (k == 20);
            check("b2b_en0", ser_en, en0);
            check("b2b_rv0", rx_valid, rv0);
            check("b2b_en2", ser_en2, en2);
            check("b2b_rv2", rx_valid2, rv2);
            if (rv0) check("b2b_rxd0", rx_data, 8'h5A);
            if (rv2) check("b2b_rxd2", rx_data2, 8'h5A);
            if (k >= 9 && k <= 11) check("b2b_rdy2", tx_ready2, k == 11);
            if (k == 9 || k == 10) check("b2b_busy2", busy2, 1);
        end

`ifdef SHIFT_SEQ_ABORT_EN
        tx_data  = 8'h99;
        tx_dir   = 1'b0;
        lb       = 1'b1;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abt_busy", busy, 0);
        check("abt_en", ser_en, 0);
        check("abt_ready", tx_ready, 1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("abt_no_rxv", rx_valid, 0);
        end
        check("abt_rxd", rx_data, 8'h5A);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
